sgb_packet_rx: RTL and testbench
================================

# sgb_packet_rx

Receives Super Game Boy command packets that the Game Boy core signals on its joypad select lines (P14/P15) and presents them to the SNES side as a 16-byte holding buffer plus status. It sits between the GB core's joypad register output and the SGB mapper's $6000/$7000 register decode. The mapper forwards decoded CPU read strobes here and returns `dout` on the SNES data bus.

## Interface
Parameters: none.

- `clk` in 1: MCLK; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `p14` in 1: GB joypad select P14, active low; same clock domain.
- `p15` in 1: GB joypad select P15, active low.
- `rd_addr` in 5: read register select.
  - 0x00–0x0F: packet byte n.
  - 0x10: status.
  - 0x11–0x1F: read as 0x00.
- `rd_pulse` in 1: one-cycle read strobe for `rd_addr`, issued once per SNES read access.
- `dout` out 8: combinational read data for `rd_addr`.
- `packet_ready` out 1: holding buffer contains an unread packet.
- `busy` out 1: a packet is being received.
- `overrun` out 1: sticky; a complete packet was dropped.

## Operation
- Line code is {p15,p14}, registered once into `code_q`. The FSM acts only on `code_q`.
  - 11: release.
  - 10: bit 0.
  - 01: bit 1.
  - 00: reset pulse.
- FSM states:
  - IDLE: on 00 go to RST.
  - RST: on 11 clear `bitcnt` and go to BIT_WAIT.
  - BIT_WAIT:
    - On 10 or 01, shift the bit in and go to BIT_REL.
    - If `bitcnt`==128 (all data bits received), 10 is the stop bit and triggers completion; 01 is a framing error and goes to IDLE with nothing stored.
    - On 00 go to RST.
  - BIT_REL: on 11 go to BIT_WAIT. On 00 go to RST. 10/01 hold.
  - 00 in any state goes to RST. A reset pulse always aborts and restarts the packet.
- Shift register: 128 bits. New bit enters at bit 127 and the register shifts right, so after 128 bits byte n = sr[8n+7:8n], LSB-first order. `bitcnt` is 8 bits (0..128) and increments on each data bit.
- Completion, on the stop bit:
  - If `packet_ready`=0: copy sr to the holding buffer and set `packet_ready`.
  - If `packet_ready`=1: discard the packet, leave the holding buffer unchanged, set `overrun`.
  - In both cases, go to IDLE.
- Status byte at 0x10: {5'b0, busy, overrun, packet_ready}.
- `busy` = 1 in RST, BIT_WAIT and BIT_REL.
- A `rd_pulse` with `rd_addr`==0x0F clears `packet_ready` at that edge; `dout` for that access still returns byte 15.
- A `rd_pulse` with `rd_addr`==0x10 clears `overrun` at that edge; `dout` shows the pre-clear value.
- Other addresses have no side effects.
- The holding buffer is written only on an accepted completion, so reads stay stable while the next packet is being received.

## Timing
- Reset values:
  - FSM = IDLE; `code_q` = 11; sr, buffer and `bitcnt` = 0.
  - `packet_ready`, `busy`, `overrun` = 0; `dout` = 0x00 for every address.
- Port-to-state latency is 1 cycle (`code_q`); state and flag updates take effect on the following edge. `packet_ready` rises 2 clk edges after the stop-bit code appears on the ports.
- A code held for many cycles counts once; only state transitions consume codes. No timeout.
- Simultaneous events:
  - Completion on the same edge as a 0x0F `rd_pulse`: the clear wins first, the new packet is accepted, and `packet_ready` ends at 1 with the new data.
  - Completion while `packet_ready`=1 on the same edge as a 0x10 `rd_pulse`: `overrun` ends at 1, because set wins.
- `rst_n` low mid-packet immediately returns all state to reset values; any partial packet is lost.

## Test plan
- Full packet:
  - Stimulus: reset pulse, 128 bits encoding bytes 0x00..0x0F (byte n = n), stop bit 10.
  - Response: `packet_ready`=1 two edges after the stop code; reads of 0x00–0x0F return 0x00–0x0F; status=0x01; after the 0x0F read, status=0x00.
- Framing error:
  - Stimulus: 128 bits, then 01 in place of the stop bit.
  - Response: `packet_ready` stays 0, `busy`=0, holding buffer unchanged.
- Mid-packet restart:
  - Stimulus: 40 bits, 00, then a full packet of 0xA5 bytes.
  - Response: all 16 bytes read 0xA5.
- Overrun:
  - Stimulus: two packets (0x11…, then 0x22…) with no reads between them.
  - Response: buffer holds 0x11 bytes; status=0x03; a status read returns 0x03, then 0x01.
- Same-edge accept:
  - Stimulus: 0x0F `rd_pulse` on the completion edge of a 0x33 packet.
  - Response: `packet_ready`=1, buffer = 0x33, `overrun`=0.
- Async reset:
  - Stimulus: `rst_n` pulsed low after 70 bits.
  - Response: all outputs 0 immediately; the next full packet is received correctly.

Source files
------------

// File: rtl/sgb_packet_rx.sv
// Super Game Boy command packet receiver: decodes the P14/P15 line code into a
// 128-bit packet, latches it into a 16-byte holding buffer and exposes status.
module sgb_packet_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       p14,
    input  logic       p15,
    input  logic [4:0] rd_addr,
    input  logic       rd_pulse,
    output logic [7:0] dout,
    output logic       packet_ready,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RST      = 2'd1,
        ST_BIT_WAIT = 2'd2,
        ST_BIT_REL  = 2'd3
    } state_t;

    localparam logic [1:0] CODE_RESET   = 2'b00;
    localparam logic [1:0] CODE_BIT1    = 2'b01;
    localparam logic [1:0] CODE_BIT0    = 2'b10;
    localparam logic [1:0] CODE_RELEASE = 2'b11;

    state_t         state_r;
    state_t         state_next_s;
    logic [1:0]     code_r;
    logic [7:0]     bitcnt_r;
    logic [127:0]   sr_r;
    logic [127:0]   buf_r;
    logic           pkt_ready_r;
    logic           overrun_r;

    logic           shift_s;
    logic           clr_cnt_s;
    logic           complete_s;
    logic           rd_clr_ready_s;
    logic           rd_clr_ovr_s;
    logic           accept_s;
    logic           drop_s;

    // Line code register; the FSM only ever looks at this registered copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_r <= CODE_RELEASE;
        end else begin
            code_r <= {p15, p14};
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; a reset code from any state restarts the packet
    always_comb begin
        state_next_s = state_r;
        shift_s      = 1'b0;
        clr_cnt_s    = 1'b0;
        complete_s   = 1'b0;
        if (code_r == CODE_RESET) begin
            state_next_s = ST_RST;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_IDLE;
                end
                ST_RST: begin
                    if (code_r == CODE_RELEASE) begin
                        clr_cnt_s    = 1'b1;
                        state_next_s = ST_BIT_WAIT;
                    end else begin
                        state_next_s = ST_RST;
                    end
                end
                ST_BIT_WAIT: begin
                    if (code_r == CODE_RELEASE) begin
                        state_next_s = ST_BIT_WAIT;
                    end else if (bitcnt_r == 8'd128) begin
                        // After all data bits only a 0 is a valid stop bit
                        complete_s   = (code_r == CODE_BIT0);
                        state_next_s = ST_IDLE;
                    end else begin
                        shift_s      = 1'b1;
                        state_next_s = ST_BIT_REL;
                    end
                end
                ST_BIT_REL: begin
                    if (code_r == CODE_RELEASE) begin
                        state_next_s = ST_BIT_WAIT;
                    end else begin
                        state_next_s = ST_BIT_REL;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Bit counter and LSB-first shift register (new bit enters at the top)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt_r <= 8'd0;
            sr_r     <= 128'd0;
        end else begin
            if (clr_cnt_s) begin
                bitcnt_r <= 8'd0;
            end else if (shift_s) begin
                bitcnt_r <= bitcnt_r + 8'd1;
            end
            if (shift_s) begin
                sr_r <= {(code_r == CODE_BIT1), sr_r[127:1]};
            end
        end
    end

    assign rd_clr_ready_s = rd_pulse && (rd_addr == 5'h0F);
    assign rd_clr_ovr_s   = rd_pulse && (rd_addr == 5'h10);
    // A same-edge read of byte 15 frees the buffer in time for the new packet
    assign accept_s       = complete_s && (!pkt_ready_r || rd_clr_ready_s);
    assign drop_s         = complete_s && pkt_ready_r && !rd_clr_ready_s;

    // Holding buffer and status flags; set beats clear on overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_r       <= 128'd0;
            pkt_ready_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                buf_r       <= sr_r;
                pkt_ready_r <= 1'b1;
            end else if (rd_clr_ready_s) begin
                pkt_ready_r <= 1'b0;
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (rd_clr_ovr_s) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign packet_ready = pkt_ready_r;
    assign overrun      = overrun_r;
    assign busy         = (state_r != ST_IDLE);

    // Read data mux: buffer bytes, status, then zeros
    always_comb begin
        dout = 8'h00;
        if (!rd_addr[4]) begin
            dout = buf_r[{rd_addr[3:0], 3'b000} +: 8];
        end else if (rd_addr[3:0] == 4'h0) begin
            dout = {5'b00000, busy, overrun_r, pkt_ready_r};
        end else begin
            dout = 8'h00;
        end
    end

endmodule

// File: tb/tb_sgb_packet_rx.sv
// Randomized bench for sgb_packet_rx: reads are scored against a byte-level
// packet model through an expectation queue drained by an independent monitor.
module tb_sgb_packet_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       p14 = 1'b1;
    logic       p15 = 1'b1;
    logic [4:0] rd_addr = 5'd0;
    logic       rd_pulse = 1'b0;
    logic [7:0] dout;
    logic       packet_ready;
    logic       busy;
    logic       overrun;

    sgb_packet_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .p14          (p14),
        .p15          (p15),
        .rd_addr      (rd_addr),
        .rd_pulse     (rd_pulse),
        .dout         (dout),
        .packet_ready (packet_ready),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
    } rd_exp_t;

    rd_exp_t    exp_q[$];
    logic [7:0] m_buf [16];
    bit         m_ready;
    bit         m_ovr;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [4:0] a);
        if (a < 5'h10) return m_buf[a[3:0]];
        if (a == 5'h10) return {5'b00000, 1'b0, m_ovr, m_ready};
        return 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_buf[i] = 8'h00;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // One read access: expected data comes from the model before side effects
    task automatic do_read(input logic [4:0] a);
        rd_exp_t e;
        @(negedge clk);
        rd_addr  = a;
        rd_pulse = 1'b1;
        e.addr = a;
        e.data = model_read(a);
        exp_q.push_back(e);
        if (a == 5'h0F) m_ready = 1'b0;
        if (a == 5'h10) m_ovr = 1'b0;
        @(negedge clk);
        rd_pulse = 1'b0;
    endtask

    task automatic drive(input logic [1:0] c, input int cyc);
        @(negedge clk);
        {p15, p14} = c;
        repeat (cyc - 1) @(negedge clk);
    endtask

    // Reset pulse, then the first n bits of pkt, bit 0 of byte 0 first
    task automatic send_bits(input logic [127:0] pkt, input int n);
        drive(2'b00, $urandom_range(1, 2));
        drive(2'b11, $urandom_range(1, 2));
        for (int i = 0; i < n; i++) begin
            drive(pkt[i] ? 2'b01 : 2'b10, $urandom_range(1, 3));
            drive(2'b11, $urandom_range(1, 2));
        end
    endtask

    task automatic send_packet(input logic [127:0] pkt, input logic [1:0] stop, input bit same_edge);
        send_bits(pkt, 128);
        @(negedge clk);
        {p15, p14} = stop;
        if (same_edge) begin
            do_read(5'h0F);
        end else begin
            @(negedge clk);
            check8("ready_one_edge", {7'b0, packet_ready}, {7'b0, m_ready});
            check8("busy_before_stop", {7'b0, busy}, 8'h01);
            @(negedge clk);
        end
        if (stop == 2'b10) begin
            if (!m_ready) begin
                for (int n = 0; n < 16; n++) m_buf[n] = pkt[8*n +: 8];
                m_ready = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end
        check8("ready_two_edges", {7'b0, packet_ready}, {7'b0, m_ready});
        check8("overrun_after_stop", {7'b0, overrun}, {7'b0, m_ovr});
        check8("busy_after_stop", {7'b0, busy}, 8'h00);
        {p15, p14} = 2'b11;
    endtask

    task automatic read_range(input int first, input int last);
        for (int i = first; i <= last; i++) do_read(5'(i));
    endtask

    function automatic logic [127:0] fill(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic logic [127:0] rand_pkt();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: every presented read is compared against the queued expectation
    initial begin : monitor
        rd_exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rd_pulse) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL read_unexpected: addr %02h got %02h, expected no access", rd_addr, dout);
                end else begin
                    e = exp_q.pop_front();
                    check8($sformatf("read_%02h", e.addr), dout, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        n_fail++;
        $display("FAIL watchdog: run did not complete within the time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : stimulus
        logic [127:0] pkt;
        logic [4:0]   probe [5];
        probe = '{5'h00, 5'h07, 5'h0F, 5'h10, 5'h1F};
        model_reset();
        repeat (3) @(negedge clk);
        check8("reset_ready", {7'b0, packet_ready}, 8'h00);
        check8("reset_busy", {7'b0, busy}, 8'h00);
        check8("reset_overrun", {7'b0, overrun}, 8'h00);
        for (int i = 0; i < 5; i++) begin
            rd_addr = probe[i];
            #1;
            check8($sformatf("reset_dout_%02h", probe[i]), dout, 8'h00);
        end
        rst_n = 1'b1;

        // Full packet, byte n = n
        for (int n = 0; n < 16; n++) pkt[8*n +: 8] = 8'(n);
        send_packet(pkt, 2'b10, 1'b0);
        do_read(5'h10);
        read_range(0, 15);
        do_read(5'h10);
        do_read(5'h13);

        // Framing error leaves the buffer alone
        send_packet(rand_pkt(), 2'b01, 1'b0);
        read_range(0, 15);
        do_read(5'h10);

        // Restart after 40 bits
        send_bits(rand_pkt(), 40);
        send_packet(fill(8'hA5), 2'b10, 1'b0);
        read_range(0, 15);
        do_read(5'h10);

        // Overrun: second packet dropped
        send_packet(fill(8'h11), 2'b10, 1'b0);
        send_packet(fill(8'h22), 2'b10, 1'b0);
        read_range(0, 14);
        do_read(5'h10);
        do_read(5'h10);

        // Byte-15 read on the completion edge
        send_packet(fill(8'h33), 2'b10, 1'b1);
        read_range(0, 14);
        do_read(5'h10);

        // Asynchronous reset after 70 bits
        send_bits(rand_pkt(), 70);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check8("async_ready", {7'b0, packet_ready}, 8'h00);
        check8("async_busy", {7'b0, busy}, 8'h00);
        check8("async_overrun", {7'b0, overrun}, 8'h00);
        rd_addr = 5'h03;
        #1;
        check8("async_dout_03", dout, 8'h00);
        rd_addr = 5'h10;
        #1;
        check8("async_dout_10", dout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        pkt = rand_pkt();
        send_packet(pkt, 2'b10, 1'b0);
        read_range(0, 15);
        do_read(5'h10);

        // Random packets with random read order
        for (int k = 0; k < 3; k++) begin
            send_packet(rand_pkt(), 2'b10, 1'b0);
            repeat (6) do_read(5'($urandom_range(0, 14)));
            do_read(5'($urandom_range(17, 31)));
            do_read(5'h0F);
            do_read(5'h10);
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d reads still pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
